shift_unit: RTL

Multi-cycle, variable-amount 16-bit shift unit for the datapath.
- Accepts an operand, a shift operation and a 4-bit shift amount through a start/done handshake.
- Applies the single-bit shift once per clock until the amount is exhausted.
- Holds the result for the register-file writeback stage.
- Serves shift instructions that need more than the one-position shift supported by the combinational datapath shifter, and is sequenced by the controller FSM.

---
 rtl/shift_unit.sv | 94 +++++++++
 1 files changed

// File: rtl/shift_unit.sv
// shift_unit: multi-cycle 16-bit shifter, one bit position per clock.
// Optional rotate for op=00 under `define SHIFT_UNIT_ROR_EN.
module shift_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [1:0]  op,
  input  logic [3:0]  amt,
  output logic        busy,
  output logic        done,
  output logic [15:0] sout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] res_q, res_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        accept;

  function automatic logic [15:0] step(
    input logic [15:0] a,
    input logic [1:0]  o
  );
    logic [15:0] r;
    unique case (o)
      2'b01: r = {a[14:0], 1'b0};
      2'b10: r = {1'b0, a[15:1]};
      2'b11: r = {a[15], a[15:1]};
`ifdef SHIFT_UNIT_ROR_EN
      default: r = {a[0], a[15:1]};
`else
      default: r = a;
`endif
    endcase
    return r;
  endfunction

  // next-state, datapath and output decode
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    accept  = start && (state_q != SHIFT);
    res_d   = (state_q == SHIFT) ? res_q : acc_q;
    busy    = (state_q == SHIFT);
    done    = (state_q == DONE);
    sout    = (state_q == SHIFT) ? res_q : acc_q;

    unique case (state_q)
      SHIFT: begin
        acc_d = step(acc_q, op_q);
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      acc_d   = in;
      op_d    = op;
      cnt_d   = amt;
      state_d = (amt != 4'd0) ? SHIFT : DONE;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 16'h0000;
      res_q   <= 16'h0000;
      cnt_q   <= 4'd0;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

endmodule
